// File: rtl/apb_initiator_if.sv
// Signal bundle for apb_initiator: request/response handshake plus the APB bus.
// master is the initiator's view; slave is the requester + APB target side.
interface apb_initiator_if #(
    parameter int APB_AW = 10,
    parameter int APB_DW = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [APB_AW-1:0] req_addr_i;
    logic [APB_DW-1:0] req_wdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [APB_DW-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    logic [APB_AW-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
               PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: valid/ready request -> APB SETUP/ACCESS -> response.
// Define APB_TIMEOUT_EN to add a watchdog that aborts ACCESS after TIMEOUT_CYCLES stalled cycles.
module apb_initiator #(
    parameter int APB_AW         = 10,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    apb_initiator_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic [APB_AW-1:0] addr_q;
    logic [APB_DW-1:0] wdata_q;
    logic              write_q;

    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_load;
    logic              rsp_load;
    logic              misaligned;
    logic              timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    assign misaligned = (bus.req_addr_i[1:0] != 2'b00);

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Counts stalled ACCESS cycles already seen; the current stalled cycle is the last allowed one
    // when the count equals TIMEOUT_CYCLES-1, so ACCESS lasts exactly TIMEOUT_CYCLES cycles.
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (req_load) begin
            to_cnt_q <= '0;
        end else if (state_q == ACCESS && !bus.PREADY) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && !bus.PREADY &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
    always_comb begin
        state_d  = state_q;
        req_load = 1'b0;
        rsp_load = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (misaligned) begin
                        // Rejected locally: the bus never sees this request.
                        state_d  = RESP;
                        rsp_load = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        req_load = 1'b1;
                    end
                end
            end

            SETUP: begin
                state_d = ACCESS;
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                    err_d    = bus.PSLVERR;
                    if (!write_q && !bus.PSLVERR) begin
                        rdata_d = bus.PRDATA;
                    end
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                    err_d    = 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the holding registers are reset because they drive PADDR/PWRITE/PWDATA directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (req_load) begin
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            write_q <= bus.req_write_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rsp_load) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Every output is either a register or a pure decode of state_q.
    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    assign bus.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE = (state_q == ACCESS);
    assign bus.PADDR   = addr_q;
    assign bus.PWRITE  = write_q;
    assign bus.PWDATA  = wdata_q;

    a_rsp_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == RESP && !bus.rsp_ready_i) |=>
        (state_q == RESP && $stable(rdata_q) && $stable(err_q)));

    a_bus_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SETUP || (state_q == ACCESS && !bus.PREADY && !timeout_hit)) |=>
        (state_q == ACCESS && $stable(addr_q) && $stable(wdata_q) && $stable(write_q)));

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: transaction-level model + per-cycle compare process,
// plus literal cycle-by-cycle expectations. Timeout cases run only with APB_TIMEOUT_EN.
module tb_apb_initiator;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_initiator_if #(.APB_AW(AW), .APB_DW(DW)) bus ();

    apb_initiator #(.APB_AW(AW), .APB_DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    rsp_t  exp_q[$];
    xfer_t apb_q[$];

    int            slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err   = 1'b0;
    int            wcnt      = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what a request must produce, from the rules alone.
    function automatic void push_model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input int waits, input logic [DW-1:0] rd, input logic se);
        rsp_t  r;
        xfer_t x;
        if (a % 4 != 0) begin
            r.err   = 1'b1;
            r.rdata = '0;
        end else begin
            x.addr  = a;
            x.write = w;
            x.wdata = d;
            apb_q.push_back(x);
            r.err   = (TO_EN && waits >= TO) ? 1'b1 : se;
            r.rdata = (w || r.err) ? '0 : rd;
        end
        exp_q.push_back(r);
    endfunction

    // APB target: PREADY after slv_waits stalled ACCESS cycles; junk on PRDATA/PSLVERR while stalled.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.PSEL && bus.PENABLE) begin
                if (wcnt == slv_waits) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = slv_rdata;
                    bus.PSLVERR = slv_err;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 32'hBAD0_0000 | 32'(wcnt);
                    bus.PSLVERR = 1'b1;
                    wcnt++;
                end
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
                bus.PRDATA  = 32'hBAD0_FFFF;
                wcnt        = 0;
            end
        end
    end

    // Compare process: every cycle out of reset, outputs against the model.
    logic prev_psel = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            apb_q.delete();
            prev_psel = 1'b0;
        end else begin
            check1("cmp_req_ready", bus.req_ready_o, !(bus.PSEL || bus.rsp_valid_o));
            if (bus.PENABLE) check1("cmp_access_after_setup", prev_psel, 1'b1);
            if (bus.PSEL && !bus.PENABLE) check1("cmp_setup_from_idle", prev_psel, 1'b0);
            if (bus.PSEL) begin
                check1("cmp_psel_expected", apb_q.size() != 0, 1'b1);
                if (apb_q.size() != 0) begin
                    check32("cmp_paddr", 32'(bus.PADDR), 32'(apb_q[0].addr));
                    check1("cmp_pwrite", bus.PWRITE, apb_q[0].write);
                    check32("cmp_pwdata", bus.PWDATA, apb_q[0].wdata);
                end
            end
            if (prev_psel && !bus.PSEL && apb_q.size() != 0) void'(apb_q.pop_front());
            if (bus.rsp_valid_o) begin
                check1("cmp_rsp_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check1("cmp_rsp_err", bus.rsp_err_o, exp_q[0].err);
                    check32("cmp_rsp_rdata", bus.rsp_rdata_o, exp_q[0].rdata);
                    if (bus.rsp_ready_i) void'(exp_q.pop_front());
                end
            end
            prev_psel = bus.PSEL;
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic psel, input logic pen,
                              input logic rv, input logic rr);
        check1({tag, "_psel"}, bus.PSEL, psel);
        check1({tag, "_penable"}, bus.PENABLE, pen);
        check1({tag, "_rsp_valid"}, bus.rsp_valid_o, rv);
        check1({tag, "_req_ready"}, bus.req_ready_o, rr);
    endtask

    task automatic check_reset(input string tag);
        expect_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b1);
        check32({tag, "_rdata"}, bus.rsp_rdata_o, 32'h0);
        check1({tag, "_err"}, bus.rsp_err_o, 1'b0);
        check1({tag, "_pwrite"}, bus.PWRITE, 1'b0);
        check32({tag, "_paddr"}, 32'(bus.PADDR), 32'h0);
        check32({tag, "_pwdata"}, bus.PWDATA, 32'h0);
    endtask

    // Drives a request from a post-edge point; returns just after the accepting edge (cycle 1).
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] rd, input logic se);
        bit ok = 1'b0;
        slv_waits       = waits;
        slv_rdata       = rd;
        slv_err         = se;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check1("req_accepted", ok, 1'b1);
        if (ok) push_model(w, a, d, waits, rd, se);
        to_drive();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check1(name, ok, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("in_reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset("after_reset");

        // Zero-wait write.
        to_drive();
        do_req(1'b1, 10'h004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        @(negedge clk);
        expect_ctl("t1_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        check32("t1_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        check32("t1_paddr", 32'(bus.PADDR), 32'h0000_0004);
        check1("t1_pwrite", bus.PWRITE, 1'b1);
        @(negedge clk);
        expect_ctl("t1_c2", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        expect_ctl("t1_c3", 1'b0, 1'b0, 1'b1, 1'b0);
        check1("t1_err", bus.rsp_err_o, 1'b0);
        check32("t1_rdata", bus.rsp_rdata_o, 32'h0);
        @(negedge clk);
        expect_ctl("t1_c4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Read with three wait states.
        to_drive();
        do_req(1'b0, 10'h03C, 32'h0, 3, 32'h1234_5678, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1)      expect_ctl($sformatf("t2_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0);
            else if (c <= 5) expect_ctl($sformatf("t2_c%0d", c), 1'b1, 1'b1, 1'b0, 1'b0);
            else begin
                expect_ctl($sformatf("t2_c%0d", c), 1'b0, 1'b0, 1'b1, 1'b0);
                check32("t2_rdata", bus.rsp_rdata_o, 32'h1234_5678);
                check1("t2_err", bus.rsp_err_o, 1'b0);
            end
            if (c <= 5) check32($sformatf("t2_paddr_c%0d", c), 32'(bus.PADDR), 32'h0000_003C);
        end

        // Slave error on write, then a normal read.
        to_drive();
        do_req(1'b1, 10'h008, 32'h1111_2222, 0, 32'hFFFF_FFFF, 1'b1);
        repeat (3) @(negedge clk);
        expect_ctl("t3_c3", 1'b0, 1'b0, 1'b1, 1'b0);
        check1("t3_err", bus.rsp_err_o, 1'b1);
        check32("t3_rdata", bus.rsp_rdata_o, 32'h0);
        @(negedge clk);
        check1("t3_c4_ready", bus.req_ready_o, 1'b1);
        to_drive();
        do_req(1'b0, 10'h010, 32'h0, 1, 32'hA5A5_0001, 1'b0);
        repeat (4) @(negedge clk);
        expect_ctl("t3b_c4", 1'b0, 1'b0, 1'b1, 1'b0);
        check32("t3b_rdata", bus.rsp_rdata_o, 32'hA5A5_0001);
        check1("t3b_err", bus.rsp_err_o, 1'b0);

        // Misaligned request.
        to_drive();
        do_req(1'b0, 10'h006, 32'h0, 0, 32'h7777_7777, 1'b0);
        @(negedge clk);
        expect_ctl("t4_c1", 1'b0, 1'b0, 1'b1, 1'b0);
        check1("t4_err", bus.rsp_err_o, 1'b1);
        check32("t4_rdata", bus.rsp_rdata_o, 32'h0);
        @(negedge clk);
        expect_ctl("t4_c2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Response back-pressure with a request waiting.
        to_drive();
        bus.rsp_ready_i = 1'b0;
        do_req(1'b0, 10'h020, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 10'h024;
        bus.req_wdata_i = 32'h0BAD_CAFE;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check1($sformatf("t5_c%0d_req_ready", c), bus.req_ready_o, 1'b0);
            if (c >= 3) begin
                check1($sformatf("t5_c%0d_rsp_valid", c), bus.rsp_valid_o, 1'b1);
                check32($sformatf("t5_c%0d_rdata", c), bus.rsp_rdata_o, 32'hCAFE_F00D);
            end
        end
        to_drive();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        expect_ctl("t5_c8", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        expect_ctl("t5_c9", 1'b0, 1'b0, 1'b0, 1'b1);
        push_model(1'b1, 10'h024, 32'h0BAD_CAFE, 0, 32'h0, 1'b0);
        to_drive();
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        expect_ctl("t5_c10", 1'b1, 1'b0, 1'b0, 1'b0);
        check32("t5_c10_paddr", 32'(bus.PADDR), 32'h0000_0024);
        wait_idle("t5_idle");

`ifdef APB_TIMEOUT_EN
        // Stuck slave: abort after TO ACCESS cycles.
        to_drive();
        do_req(1'b0, 10'h030, 32'h0, 1000, 32'h0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1)      expect_ctl("t6_c1", 1'b1, 1'b0, 1'b0, 1'b0);
            else if (c <= 9) expect_ctl($sformatf("t6_c%0d", c), 1'b1, 1'b1, 1'b0, 1'b0);
            else begin
                expect_ctl("t6_c10", 1'b0, 1'b0, 1'b1, 1'b0);
                check1("t6_err", bus.rsp_err_o, 1'b1);
                check32("t6_rdata", bus.rsp_rdata_o, 32'h0);
            end
        end
        // PREADY arrives in the last allowed cycle: normal completion wins.
        to_drive();
        do_req(1'b0, 10'h034, 32'h0, 7, 32'h0000_0077, 1'b0);
        repeat (10) @(negedge clk);
        expect_ctl("t6b_c10", 1'b0, 1'b0, 1'b1, 1'b0);
        check1("t6b_err", bus.rsp_err_o, 1'b0);
        check32("t6b_rdata", bus.rsp_rdata_o, 32'h0000_0077);
`endif

        // Reset pulse during a stalled ACCESS.
        to_drive();
        do_req(1'b0, 10'h038, 32'h0, 1000, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        expect_ctl("t7_c4", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_ctl("t7_rst_now", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset("t7_after");

        // Traffic after reset, top of the address space.
        to_drive();
        do_req(1'b1, 10'h3FC, 32'h55AA_55AA, 2, 32'h0, 1'b0);
        wait_idle("t8_wr_idle");
        to_drive();
        do_req(1'b0, 10'h3FC, 32'h0, 0, 32'h600D_F00D, 1'b0);
        wait_idle("t8_rd_idle");
        check1("model_drained", exp_q.size() == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
